// File: rtl/rc_count_sequencer.sv
// rc_count_sequencer: clears an external negedge ripple counter, pulses it one count at a time,
// and compares each settled value against a latched target.
module rc_count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SETTLE     = 2,
  parameter int MAX_PULSES = 16,
  localparam int PW        = $clog2(MAX_PULSES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_clk,
  output logic             cnt_rst,
  output logic [WIDTH-1:0] cnt_t,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q_sample,
  output logic [PW-1:0]    pulse_cnt
);
  typedef enum logic [2:0] {IDLE, CLR_HI, CLR_LO, PULSE_HI, PULSE_LO, SETTLE_S, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] tmr_q, tmr_d;
  logic [WIDTH-1:0] tgt_q, tgt_d, q_sample_q, q_sample_d, cnt_t_q, cnt_t_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic err_q, err_d, cnt_clk_q, cnt_clk_d, cnt_rst_q, cnt_rst_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    tgt_d       = tgt_q;
    err_d       = err_q;
    pulse_cnt_d = pulse_cnt_q;
    q_sample_d  = q_sample_q;
    if (abort && state_q != IDLE) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        tgt_d       = target;
        err_d       = 1'b0;
        pulse_cnt_d = '0;
        state_d     = CLR_HI;
      end
      CLR_HI:   state_d = CLR_LO;
      PULSE_HI: state_d = PULSE_LO;
      CLR_LO, PULSE_LO: begin
        tmr_d   = 4'(SETTLE - 1);
        state_d = SETTLE_S;
      end
      SETTLE_S: begin
        tmr_d   = tmr_q - 4'd1;
        state_d = tmr_q == 4'd0 ? CHECK : SETTLE_S;
      end
      CHECK: begin
        q_sample_d = cnt_q;
        if (cnt_q == tgt_q) state_d = DONE;
        else if (pulse_cnt_q == PW'(MAX_PULSES)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
          state_d     = PULSE_HI;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so the registers track the state they belong to.
    cnt_clk_d = state_d == CLR_HI || state_d == PULSE_HI;
    cnt_rst_d = state_d == CLR_HI || state_d == CLR_LO;
    cnt_t_d   = (state_d == PULSE_HI || state_d == PULSE_LO) ? '1 :
                (state_d == SETTLE_S || state_d == CHECK) ? cnt_t_q : '0;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      tgt_q       <= '0;
      err_q       <= 1'b0;
      pulse_cnt_q <= '0;
      q_sample_q  <= '0;
      cnt_clk_q   <= 1'b0;
      cnt_rst_q   <= 1'b0;
      cnt_t_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tgt_q       <= tgt_d;
      err_q       <= err_d;
      pulse_cnt_q <= pulse_cnt_d;
      q_sample_q  <= q_sample_d;
      cnt_clk_q   <= cnt_clk_d;
      cnt_rst_q   <= cnt_rst_d;
      cnt_t_q     <= cnt_t_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign cnt_clk   = cnt_clk_q;
  assign cnt_rst   = cnt_rst_q;
  assign cnt_t     = cnt_t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_sample  = q_sample_q;
  assign pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_rc_count_sequencer.sv
// tb_rc_count_sequencer: directed runs of the sequencer against a behavioural ripple counter.
module tb_rc_count_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic [3:0] target = '0, cnt = '0, cnt_q, cnt_t, q_sample;
  logic cnt_clk, cnt_rst, busy, done, err;
  logic [4:0] pulse_cnt;
  int n_cmp = 0, n_bad = 0, cyc_done, hi_pulses, rst_pulses, stable, done_cnt;
  always #5 clk = ~clk;
  always @(negedge cnt_clk) if (cnt_rst) cnt <= '0; else if (&cnt_t) cnt <= cnt + 4'd1;
  assign cnt_q = stuck ? 4'b0010 : cnt;
  rc_count_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target), .cnt_q(cnt_q),
    .cnt_clk(cnt_clk), .cnt_rst(cnt_rst), .cnt_t(cnt_t), .busy(busy), .done(done), .err(err),
    .q_sample(q_sample), .pulse_cnt(pulse_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // act: 0 none, 1 abort, 2 spurious start, 3 reset; applied while cycle `at` is observed
  task automatic go(input logic [3:0] tgt, input int act, input int at);
    logic [3:0] prev;
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    target    = tgt + 4'd5;
    cyc_done  = 0;
    hi_pulses = 0;
    rst_pulses = 0;
    stable    = 0;
    prev      = cnt_q;
    for (int n = 1; n <= 120; n++) begin
      if (n > 1) @(negedge clk);
      start  = 1'b0;
      stable = cnt_q == prev ? stable + 1 : 0;
      prev   = cnt_q;
      if (cnt_clk) hi_pulses++;
      if (cnt_clk && cnt_rst) rst_pulses++;
      if (done) begin
        cyc_done = n;
        break;
      end
      if (n == at && (act == 1 || act == 3)) begin
        abort = act == 1;
        reset = act == 3;
        @(negedge clk);
        abort = 1'b0;
        reset = 1'b0;
        break;
      end
      if (n == at && act == 2) begin
        start  = 1'b1;
        target = 4'd7;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cnt_clk, cnt_rst, cnt_t, busy, done, err, q_sample, pulse_cnt}, 0);
    reset = 1'b0;
    go(4'd0, 0, 0);
    chk("t0_cycles", cyc_done, 6);
    chk("t0_pulse_cnt", pulse_cnt, 0);
    chk("t0_q_sample", q_sample, 0);
    chk("t0_err", err, 0);
    chk("t0_clk_pulses", hi_pulses, 1);
    chk("t0_clk_pulses_with_rst", rst_pulses, 1);
    go(4'd3, 0, 0);
    chk("t3_cycles", cyc_done, 21);
    chk("t3_q_sample", q_sample, 3);
    chk("t3_pulse_cnt", pulse_cnt, 3);
    chk("t3_stable_cycles", stable, 4);
    go(4'd15, 0, 0);
    chk("t15_cycles", cyc_done, 81);
    chk("t15_pulse_cnt", pulse_cnt, 15);
    chk("t15_q_sample", q_sample, 15);
    chk("t15_err", err, 0);
    go(4'd1, 0, 0);
    chk("t1_cycles", cyc_done, 11);
    chk("t1_q_sample", q_sample, 1);
    stuck = 1'b1;
    go(4'd5, 0, 0);
    chk("stuck_cycles", cyc_done, 86);
    chk("stuck_err", err, 1);
    chk("stuck_pulse_cnt", pulse_cnt, 16);
    chk("stuck_q_sample", q_sample, 2);
    repeat (5) @(negedge clk);
    chk("stuck_err_sticky", err, 1);
    stuck = 1'b0;
    go(4'd0, 0, 0);
    chk("restart_err_cleared", err, 0);
    chk("restart_cycles", cyc_done, 6);
    go(4'd9, 1, 13);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_clk", cnt_clk, 0);
    chk("abort_cnt_t", cnt_t, 0);
    chk("abort_done", done, 0);
    chk("abort_pulse_cnt", pulse_cnt, 2);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    go(4'd2, 2, 5);
    chk("busy_start_cycles", cyc_done, 16);
    chk("busy_start_q_sample", q_sample, 2);
    chk("busy_start_pulse_cnt", pulse_cnt, 2);
    go(4'd9, 3, 6);
    chk("midrst_outputs", {cnt_clk, cnt_rst, cnt_t, busy, done, err, q_sample, pulse_cnt}, 0);
    go(4'd2, 0, 0);
    chk("after_rst_cycles", cyc_done, 16);
    chk("after_rst_pulse_cnt", pulse_cnt, 2);
    chk("after_rst_q_sample", q_sample, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
